// File: rtl/io_tx_queue.sv
// io_tx_queue: CPU-to-device transmit FIFO. Words are strobed to the device one at a
// time and held until acknowledged; a missing acknowledge triggers a periodic resend
// and latches a sticky error flag.
module io_tx_queue #(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned DEPTH      = 8,
    parameter int unsigned TIMEOUT    = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [DATA_WIDTH-1:0]    cpu_data,
    input  logic                     cpu_valid,
    output logic                     cpu_ready,
    output logic [DATA_WIDTH-1:0]    dev_data,
    output logic                     dev_signal,
    input  logic                     dev_ack,
    input  logic                     flush,
    input  logic                     err_clr,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     timeout_err
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;
    localparam int unsigned TW = $clog2(TIMEOUT);

    localparam logic [LW-1:0] FULL_LVL  = LW'(DEPTH);
    localparam logic [TW-1:0] TIMER_MAX = TW'(TIMEOUT - 1);

    typedef enum logic {StIdle, StWait} state_e;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]         r_head;
    logic [AW-1:0]         r_tail;
    logic [LW-1:0]         r_level;
    state_e                r_state;
    logic [TW-1:0]         r_timer;
    logic [DATA_WIDTH-1:0] r_dev_data;
    logic                  r_dev_signal;
    logic                  r_timeout_err;

    logic w_full;
    logic w_push;
    logic w_pop;
    logic w_start;
    logic w_resend;

    // Full/empty come from the level counter, never from a pointer compare.
    assign w_full   = (r_level == FULL_LVL);
    // Flush overrides every other queue or FSM action.
    assign w_push   = cpu_valid && !w_full && !flush;
    assign w_pop    = (r_state == StWait) && dev_ack && !flush;
    assign w_start  = (r_state == StIdle) && (r_level != '0) && !flush;
    assign w_resend = (r_state == StWait) && !dev_ack && (r_timer == TIMER_MAX) && !flush;

    assign cpu_ready   = !w_full;
    assign level       = r_level;
    assign dev_data    = r_dev_data;
    assign dev_signal  = r_dev_signal;
    assign timeout_err = r_timeout_err;

    // Storage array: written at the tail on every accepted push; contents need no reset.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_tail] <= cpu_data;
        end
    end

    // Queue pointers and occupancy; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_level <= '0;
        end else if (flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_level <= '0;
        end else begin
            if (w_push) begin
                r_tail <= r_tail + AW'(1);
            end
            if (w_pop) begin
                r_head <= r_head + AW'(1);
            end
            unique case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LW'(1);
                2'b01:   r_level <= r_level - LW'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    // Transfer FSM with registered strobe, data, resend timer and sticky error.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= StIdle;
            r_timer       <= '0;
            r_dev_data    <= '0;
            r_dev_signal  <= 1'b0;
            r_timeout_err <= 1'b0;
        end else begin
            if (flush) begin
                // dev_data deliberately keeps its last value across a flush.
                r_state      <= StIdle;
                r_timer      <= '0;
                r_dev_signal <= 1'b0;
            end else begin
                unique case (r_state)
                    StIdle: begin
                        r_dev_signal <= 1'b0;
                        if (w_start) begin
                            r_dev_data   <= r_mem[r_head];
                            r_dev_signal <= 1'b1;
                            r_timer      <= '0;
                            r_state      <= StWait;
                        end
                    end
                    StWait: begin
                        if (w_pop) begin
                            r_dev_signal <= 1'b0;
                            r_state      <= StIdle;
                        end else if (w_resend) begin
                            r_dev_signal <= 1'b1;
                            r_timer      <= '0;
                        end else begin
                            r_dev_signal <= 1'b0;
                            r_timer      <= r_timer + TW'(1);
                        end
                    end
                    default: begin
                        r_state      <= StIdle;
                        r_dev_signal <= 1'b0;
                    end
                endcase
            end

            // A resend sets the error even if a clear is requested in the same cycle.
            if (w_resend) begin
                r_timeout_err <= 1'b1;
            end else if (err_clr) begin
                r_timeout_err <= 1'b0;
            end
        end
    end

endmodule
